// File: rtl/bitwise_result_fifo.sv
// Annotating FIFO for AND/OR/XOR result triples: tags each triple with the operand
// Hamming distance, an equality flag and a consistency flag, then buffers it for a consumer.
module bitwise_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int HDW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_and,
    input  logic [WIDTH-1:0] in_or,
    input  logic [WIDTH-1:0] in_xor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_and,
    output logic [WIDTH-1:0] out_or,
    output logic [WIDTH-1:0] out_xor,
    output logic [HDW-1:0]   out_hd,
    output logic             out_eq,
    output logic             out_bad,
    output logic [15:0]      acc_count,
    output logic [7:0]       err_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = 3 * WIDTH + HDW + 2;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    function automatic logic [HDW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [HDW-1:0] cnt;
        cnt = {HDW{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + HDW'(v[i]);
        end
        return cnt;
    endfunction

    logic [EW-1:0]   mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     acc_q, acc_d;
    logic [7:0]      err_q, err_d;

    logic            push_s;
    logic            pop_s;
    logic [HDW-1:0]  hd_s;
    logic            eq_s;
    logic            bad_s;
    logic [EW-1:0]   entry_s;
    logic [EW-1:0]   head_s;

    // A triple is consistent only if AND and XOR are disjoint and together form OR.
    always_comb begin
        hd_s    = popcount(in_xor);
        eq_s    = (in_xor == {WIDTH{1'b0}});
        bad_s   = (in_or != (in_and | in_xor)) || ((in_and & in_xor) != {WIDTH{1'b0}});
        entry_s = {in_and, in_or, in_xor, hd_s, eq_s, bad_s};
    end

    // Handshakes; readiness depends only on registered occupancy, so a pop never frees a slot early.
    always_comb begin
        in_ready  = !rst && (count_q != FULL_CNT);
        out_valid = (count_q != {CW{1'b0}});
        push_s    = in_valid && in_ready;
        pop_s     = out_valid && out_ready;
    end

    // Next-state for pointers, occupancy and statistics counters.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        acc_d    = acc_q;
        err_d    = err_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            acc_d    = acc_q + 16'd1;
            if (bad_s && (err_q != 8'hFF)) begin
                err_d = err_q + 8'd1;
            end else begin
                err_d = err_q;
            end
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register with asynchronous flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            acc_q    <= 16'd0;
            err_q    <= 8'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            err_q    <= err_d;
        end
    end

    // Entry storage; contents are meaningless until written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= entry_s;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    // Head entry is always presented, even when out_valid is low.
    always_comb begin
        head_s    = mem_q[rd_ptr_q];
        out_and   = head_s[EW-1 -: WIDTH];
        out_or    = head_s[EW-1-WIDTH -: WIDTH];
        out_xor   = head_s[EW-1-2*WIDTH -: WIDTH];
        out_hd    = head_s[HDW+1 : 2];
        out_eq    = head_s[1];
        out_bad   = head_s[0];
        acc_count = acc_q;
        err_count = err_q;
    end

endmodule

// File: doc/bitwise_result_fifo.md
# bitwise_result_fifo

Downstream consumer of the 8-bit bitwise operation stage. It accepts one AND/OR/XOR result triple per valid/ready handshake and checks the triple for internal consistency. It annotates each triple with the Hamming distance of the operands (popcount of XOR) and an equality flag, then buffers the annotated entries in a DEPTH-entry FIFO for a valid/ready consumer such as a scoreboard or logger.

## Interface
- WIDTH, 8, operand/result width.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- HDW, $clog2(WIDTH+1) (4 at default), width of Hamming-distance field.

- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  upstream triple present.
- in_ready  output  1  block can accept this cycle.
- in_and / in_or / in_xor  input  WIDTH  result triple from the bitwise stage.
- out_valid  output  1  FIFO head entry present.
- out_ready  input  1  downstream takes head entry.
- out_and / out_or / out_xor  output  WIDTH  head triple.
- out_hd  output  HDW  popcount(head xor).
- out_eq  output  1  head xor == 0 (operands equal).
- out_bad  output  1  head triple inconsistent.
- acc_count  output  16  accepted triples, wrapping.
- err_count  output  8  accepted inconsistent triples, saturating at 255.

## Operation
- Accept: in_valid && in_ready at a rising edge. Accepting writes one entry at the write pointer.
- Entry contents, computed combinationally from the inputs at accept:
  - and, or, xor copied unchanged.
  - hd = popcount(in_xor).
  - eq = (in_xor == 0).
  - bad = (in_or != (in_and | in_xor)) || ((in_and & in_xor) != 0).
- Pop: out_valid && out_ready at a rising edge. Pop advances the read pointer.
- Occupancy counter range 0..DEPTH. Pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0.
- in_ready = !rst && (occupancy != DEPTH).
  - Depends only on registered occupancy, never on out_ready.
  - When full, no push occurs even if a pop happens in the same cycle.
- out_valid = (occupancy != 0). Out fields show the head entry and hold stable while out_valid && !out_ready.
- Push and pop in the same edge with 0 < occupancy < DEPTH: occupancy unchanged, both pointers advance.
- Empty: no bypass. An entry pushed into an empty FIFO is not visible until the next cycle.
- acc_count increments by 1 on every accept and wraps 0xFFFF→0.
- err_count increments on every accept with bad=1 and holds at 255.
- Out fields while out_valid=0 are don't-care. The implementation drives them from the entry at the read pointer.

## Timing
- Reset values: in_ready=0 while rst is high, 1 the first cycle after release.
  - out_valid=0, occupancy=0, pointers=0.
  - acc_count=0, err_count=0.
  - FIFO storage need not be cleared.
- Reset mid-operation flushes all entries immediately (asynchronous). In-flight handshakes are lost, and counters clear.
- Latency: triple accepted at edge N appears at out_* with out_valid=1 in the cycle after edge N (1-cycle minimum).
- Throughput: one accept and one pop per cycle sustained when 0 < occupancy < DEPTH.
- Ordering: strict FIFO; no entry is dropped or duplicated.

## Test plan
- Basic annotate: after reset, push and=00000000, or=11111111, xor=11111111, with out_ready=1.
  - Next cycle: out_valid=1, out_hd=8, out_eq=0, out_bad=0.
  - Then push and=00001100, or=11111111, xor=11110011 → out_hd=6, out_bad=0.
  - acc_count=2, err_count=0.
- Inconsistent triples: push and=00000001, or=00000000, xor=00000001 → out_bad=1, err_count=1.
  - Then push xor=0, and=or=10101010 → out_eq=1, out_hd=0, out_bad=0.
- Full/backpressure: out_ready=0, in_valid=1 with 5 distinct triples.
  - in_ready drops after the 4th accept, and the 5th is held.
  - With out_ready=1, the first freed slot accepts the 5th triple one cycle after the pop, not in the same cycle.
  - Pop order is 1,2,3,4,5.
- Simultaneous push/pop at occupancy 2 for 20 cycles: occupancy stays 2, pointers wrap cleanly, outputs come out in order.
- Reset mid-stream: assert rst asynchronously with 3 entries stored.
  - out_valid, in_ready, acc_count and err_count go to 0 without a clock edge.
  - After release, the first push appears alone.
- Saturation: accept 300 bad triples → err_count=255, acc_count=300. Then force acc_count to 0xFFFF, accept one triple → acc_count=0.
